// File: rtl/packer_pkg.sv
// Shared types and defaults for the byte lane packer family.
package packer_pkg;

   typedef enum logic {LSB_FIRST, MSB_FIRST} lane_order_e;
   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

   localparam int unsigned PACKER_ELEM_W = 8;
   localparam int unsigned PACKER_LANES  = 4;

   typedef logic [PACKER_ELEM_W-1:0]              packer_elem_t;
   typedef logic [PACKER_LANES*PACKER_ELEM_W-1:0] packer_word_t;

   // Lane counter width; a single-lane packer still carries a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/byte_lane_packer_if.sv
// Narrow-in / wide-out stream bundle between a producer, the packer and a sink.
interface byte_lane_packer_if
   import packer_pkg::*;
#(
   parameter int unsigned ELEM_W = PACKER_ELEM_W,
   parameter int unsigned LANES  = PACKER_LANES
);

   logic                    in_valid;
   logic                    in_ready;
   logic [ELEM_W-1:0]       in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*ELEM_W-1:0] out_data;
   logic [LANES-1:0]        out_keep;
   logic                    out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

endinterface

// File: rtl/packer_accum.sv
// Partial-word accumulator: lane counter, lane steering, keep mask and completion detect.
module packer_accum
   import packer_pkg::*;
#(
   parameter int unsigned ELEM_W     = PACKER_ELEM_W,
   parameter int unsigned LANES      = PACKER_LANES,
   parameter lane_order_e LANE_ORDER = LSB_FIRST
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    take,
   input  logic [ELEM_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    complete,
   output logic [LANES*ELEM_W-1:0] word_data,
   output logic [LANES-1:0]        word_keep
);

   localparam int unsigned CNT_W = cnt_width(LANES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES - 1);

   typedef logic [LANES*ELEM_W-1:0] word_t;
   typedef logic [LANES-1:0]        keep_t;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lane;
   word_t            acc_data;
   keep_t            acc_keep;

   always_comb begin
      lane = (LANE_ORDER == MSB_FIRST) ? (CNT_MAX - cnt) : cnt;
   end

   // Target lane is still zero in the accumulator, so OR-merge is enough.
   always_comb begin
      word_data = acc_data;
      word_keep = acc_keep;
      complete  = 1'b0;
      if (take) begin
         word_data = acc_data | (word_t'(in_data) << (lane * ELEM_W));
         word_keep = acc_keep | (keep_t'(1) << lane);
         complete  = (cnt == CNT_MAX) || in_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc_data <= '0;
         acc_keep <= '0;
      end else if (complete) begin
         cnt      <= '0;
         acc_data <= '0;
         acc_keep <= '0;
      end else if (take) begin
         cnt      <= cnt + 1'b1;
         acc_data <= word_data;
         acc_keep <= word_keep;
      end
   end

endmodule

// File: rtl/byte_lane_packer.sv
// Packs narrow elements into LANES-wide words; output register with valid/ready hold.
module byte_lane_packer
   import packer_pkg::*;
#(
   parameter int unsigned ELEM_W     = PACKER_ELEM_W,
   parameter int unsigned LANES      = PACKER_LANES,
   parameter lane_order_e LANE_ORDER = LSB_FIRST
) (
   input  logic             clk,
   input  logic             rst_n,
   byte_lane_packer_if.slave bus
);

   typedef logic [ELEM_W-1:0]       elem_t;
   typedef logic [LANES*ELEM_W-1:0] word_t;

   if ($bits(elem_t) != ELEM_W) begin : g_chk_elem
      $fatal(1, "byte_lane_packer: elem_t width mismatch");
   end
   if ($bits(word_t) != LANES * ELEM_W) begin : g_chk_word
      $fatal(1, "byte_lane_packer: word_t width mismatch");
   end
   if (LANES < 1) begin : g_chk_lanes
      $fatal(1, "byte_lane_packer: LANES must be at least 1");
   end

   out_state_e       state;
   word_t            out_data_q;
   logic [LANES-1:0] out_keep_q;
   logic             out_last_q;
   logic             in_ready;
   logic             take;
   logic             complete;
   word_t            nxt_data;
   logic [LANES-1:0] nxt_keep;

   assign in_ready      = (state == OUT_EMPTY) || bus.out_ready;
   assign take          = bus.in_valid && in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == OUT_FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_keep  = out_keep_q;
   assign bus.out_last  = out_last_q;

   packer_accum #(
      .ELEM_W    (ELEM_W),
      .LANES     (LANES),
      .LANE_ORDER(LANE_ORDER)
   ) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .take     (take),
      .in_data  (bus.in_data),
      .in_last  (bus.in_last),
      .complete (complete),
      .word_data(nxt_data),
      .word_keep(nxt_keep)
   );

   // A completion while FULL implies out_ready, so the held word is leaving this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= OUT_EMPTY;
         out_data_q <= '0;
         out_keep_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         if (complete) begin
            out_data_q <= nxt_data;
            out_keep_q <= nxt_keep;
            out_last_q <= bus.in_last;
         end
         case (state)
            OUT_EMPTY: if (complete) state <= OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !complete) state <= OUT_EMPTY;
            default:   state <= OUT_EMPTY;
         endcase
      end
   end

endmodule
